// File: rtl/wifi_cmd_filter.sv
// Debounce/synchronize filter for the WiFi remote-command lines feeding the alarm FSM.
// A new 7-bit command is committed only after it has held steady for STABLE_CYCLES cycles.
module wifi_cmd_filter #(
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw_wifi,
    input  logic [2:0] raw_wifi2,
    output logic [3:0] wifi_cmd,
    output logic [2:0] wifi2_cmd,
    output logic       cmd_strobe,
    output logic       settling,
    output logic [7:0] glitch_cnt
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       r_sync1;
    logic [6:0]       r_s;
    logic [6:0]       r_cand;
    logic [6:0]       r_out;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             r_strobe;
    logic             r_settling;
    logic [7:0]       r_glitch;
    logic [7:0]       w_glitchNext;

    // Two-flop synchronizer; all seven bits move together so a single compare covers the vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_s     <= '0;
        end else begin
            r_sync1 <= {raw_wifi, raw_wifi2};
            r_s     <= r_sync1;
        end
    end

    assign w_glitchNext = (r_glitch == 8'hFF) ? r_glitch : r_glitch + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand     <= '0;
            r_out      <= '0;
            r_cnt      <= '0;
            r_state    <= ST_STABLE;
            r_strobe   <= 1'b0;
            r_settling <= 1'b0;
            r_glitch   <= '0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (r_s != r_out) begin
                        r_cand     <= r_s;
                        r_cnt      <= '0;
                        r_state    <= ST_SETTLE;
                        r_settling <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // A return to the committed value wins over any other change.
                    if (r_s == r_out) begin
                        r_state    <= ST_STABLE;
                        r_settling <= 1'b0;
                        r_glitch   <= w_glitchNext;
                    end else if (r_s != r_cand) begin
                        r_cand   <= r_s;
                        r_cnt    <= '0;
                        r_glitch <= w_glitchNext;
                    end else if (r_cnt == LAST_CNT) begin
                        r_out      <= r_cand;
                        r_strobe   <= 1'b1;
                        r_state    <= ST_STABLE;
                        r_settling <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign wifi_cmd   = r_out[6:3];
    assign wifi2_cmd  = r_out[2:0];
    assign cmd_strobe = r_strobe;
    assign settling   = r_settling;
    assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_wifi_cmd_filter.sv
// Directed bench for wifi_cmd_filter with STABLE_CYCLES=4; expected values are hand-derived
// from the edge timeline (first sampling edge = E1, commit at E7).
module tb_wifi_cmd_filter;

    logic       clk;
    logic       reset;
    logic [3:0] raw_wifi;
    logic [2:0] raw_wifi2;
    logic [3:0] wifi_cmd;
    logic [2:0] wifi2_cmd;
    logic       cmd_strobe;
    logic       settling;
    logic [7:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    wifi_cmd_filter #(
        .STABLE_CYCLES(4),
        .CNT_W        (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_wifi  (raw_wifi),
        .raw_wifi2 (raw_wifi2),
        .wifi_cmd  (wifi_cmd),
        .wifi2_cmd (wifi2_cmd),
        .cmd_strobe(cmd_strobe),
        .settling  (settling),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] w, input logic [2:0] w2);
        raw_wifi  = w;
        raw_wifi2 = w2;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wifi"},   {4'b0, wifi_cmd},   8'h00);
        checkOutput({tag, "_wifi2"},  {5'b0, wifi2_cmd},  8'h00);
        checkOutput({tag, "_strobe"}, {7'b0, cmd_strobe}, 8'h00);
        checkOutput({tag, "_settle"}, {7'b0, settling},   8'h00);
        checkOutput({tag, "_glitch"}, glitch_cnt,         8'h00);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(4'b0000, 3'b000);

        // Asynchronous reset, checked before any clock edge has occurred.
        #2 reset = 1'b1;
        #1 checkAllZero("rst_async");
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle_strobe", {7'b0, cmd_strobe}, 8'h00);
            checkOutput("idle_settle", {7'b0, settling},   8'h00);
        end

        // Clean command 1010: settling after E3..E6, commit and strobe at E7.
        applyStimulus(4'b1010, 3'b000);
        for (int e = 1; e <= 8; e++) begin
            tick();
            checkOutput("clean_wifi",   {4'b0, wifi_cmd},   (e >= 7) ? 8'h0A : 8'h00);
            checkOutput("clean_strobe", {7'b0, cmd_strobe}, (e == 7) ? 8'h01 : 8'h00);
            checkOutput("clean_settle", {7'b0, settling},   (e >= 3 && e <= 6) ? 8'h01 : 8'h00);
        end

        // Two-cycle pulse on raw_wifi2 aborts at E5 with one glitch.
        applyStimulus(4'b1010, 3'b001);
        tick();
        tick();
        applyStimulus(4'b1010, 3'b000);
        for (int e = 3; e <= 12; e++) begin
            tick();
            checkOutput("glitch_wifi2",  {5'b0, wifi2_cmd},  8'h00);
            checkOutput("glitch_strobe", {7'b0, cmd_strobe}, 8'h00);
            checkOutput("glitch_cnt",    glitch_cnt,         (e >= 5) ? 8'h01 : 8'h00);
        end

        // Bounce 1011 -> 1100: candidate reloads at E5 (glitch 2), commit at E9.
        applyStimulus(4'b1011, 3'b000);
        tick();
        tick();
        applyStimulus(4'b1100, 3'b000);
        for (int e = 3; e <= 11; e++) begin
            tick();
            checkOutput("bounce_wifi",   {4'b0, wifi_cmd},   (e >= 9) ? 8'h0C : 8'h0A);
            checkOutput("bounce_strobe", {7'b0, cmd_strobe}, (e == 9) ? 8'h01 : 8'h00);
            checkOutput("bounce_glitch", glitch_cnt,         (e >= 5) ? 8'h02 : 8'h01);
        end

        // 300 aborted settles starting from a count of 2; saturation at 255.
        for (int k = 1; k <= 300; k++) begin
            applyStimulus(4'b0000, 3'b000);
            tick();
            tick();
            applyStimulus(4'b1100, 3'b000);
            tick();
            tick();
            tick();
            if (k == 250) checkOutput("sat_mid", glitch_cnt, 8'd252);
        end
        checkOutput("sat_cnt",  glitch_cnt,       8'hFF);
        checkOutput("sat_wifi", {4'b0, wifi_cmd}, 8'h0C);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("sat_hold", glitch_cnt, 8'hFF);

        // Reset two cycles into a settle toward raw_wifi2=011 (SETTLE entered at E3).
        applyStimulus(4'b0000, 3'b011);
        for (int e = 1; e <= 5; e++) tick();
        checkOutput("pre_rst_settle", {7'b0, settling}, 8'h01);
        reset = 1'b1;
        #1 checkAllZero("rst_mid");
        tick();
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checkOutput("fresh_wifi2",  {5'b0, wifi2_cmd},  (e >= 7) ? 8'h03 : 8'h00);
            checkOutput("fresh_strobe", {7'b0, cmd_strobe}, (e == 7) ? 8'h01 : 8'h00);
            checkOutput("fresh_glitch", glitch_cnt,         8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
